// File: rtl/wb_unit.sv
// ---------------------------------------------------------------------------
// wb_unit -- writeback unit for the RISC-V core.
//
// Purpose:
//   Collects completed results from the ALU path and the load path, each
//   through a one-entry holding slot. Load data is formatted (byte/halfword
//   extraction, sign/zero extension) on the way into its slot. A fair
//   arbiter picks at most one slot per cycle and drives the register bank
//   write port. A 32-bit pending-destination scoreboard is kept for the
//   hazard logic.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alu_valid/alu_ready      ALU result channel handshake
//   alu_rd, alu_result       ALU destination index and value
//   ld_valid/ld_ready        load channel handshake
//   ld_rd, ld_data           load destination index and raw aligned word
//   ld_addr_lo, ld_funct3    byte offset and RISC-V load funct3
//   pend_set, pend_rd        issue marks a destination in flight
//   pend                     registered scoreboard, bit i = xi outstanding
//   regWrite, writePort,     registered register bank write port
//   busC
//
// Arbiter state (last_conflict):
//   state   | meaning
//   SRC_ALU | ALU won the most recent conflict; next conflict grants LD
//   SRC_LD  | LD won the most recent conflict; next conflict grants ALU
// ---------------------------------------------------------------------------
module wb_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_funct3,
  input  logic        pend_set,
  input  logic [4:0]  pend_rd,
  output logic [31:0] pend,
  output logic        regWrite,
  output logic [4:0]  writePort,
  output logic [31:0] busC
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_t;

  src_t        last_conflict;
  src_t        last_conflict_nxt;

  logic        alu_v;
  logic [4:0]  alu_rd_q;
  logic [31:0] alu_data_q;
  logic        ld_v;
  logic [4:0]  ld_rd_q;
  logic [31:0] ld_data_q;

  logic        conflict;
  logic        grant_alu;
  logic        grant_ld;
  logic        grant_any;
  logic [4:0]  win_rd;
  logic [31:0] win_data;
  logic        alu_accept;
  logic        ld_accept;
  logic [31:0] pend_nxt;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  // ---------------------------------------------------------------------
  // Load formatting on the incoming payload
  // ---------------------------------------------------------------------
  always_comb begin
    ld_byte = ld_data[7:0];
    case (ld_addr_lo)
      2'd0: ld_byte = ld_data[7:0];
      2'd1: ld_byte = ld_data[15:8];
      2'd2: ld_byte = ld_data[23:16];
      2'd3: ld_byte = ld_data[31:24];
      default: ld_byte = ld_data[7:0];
    endcase
  end

  always_comb begin
    ld_half = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
  end

  always_comb begin
    ld_fmt = ld_data;
    case (ld_funct3)
      3'b000: ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_fmt = {24'd0, ld_byte};
      3'b001: ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101: ld_fmt = {16'd0, ld_half};
      default: ld_fmt = ld_data;
    endcase
  end

  // ---------------------------------------------------------------------
  // Arbitration, handshakes and scoreboard next state
  // ---------------------------------------------------------------------
  always_comb begin
    conflict          = alu_v && ld_v;
    grant_alu         = alu_v && (!ld_v || (last_conflict == SRC_LD));
    grant_ld          = ld_v && (!alu_v || (last_conflict == SRC_ALU));
    grant_any         = grant_alu || grant_ld;

    last_conflict_nxt = last_conflict;
    if (conflict) begin
      last_conflict_nxt = grant_alu ? SRC_ALU : SRC_LD;
    end

    win_rd   = grant_alu ? alu_rd_q   : ld_rd_q;
    win_data = grant_alu ? alu_data_q : ld_data_q;

    // A slot being drained this cycle can take a new entry on the same edge.
    alu_ready  = !rst && (!alu_v || grant_alu);
    ld_ready   = !rst && (!ld_v || grant_ld);
    alu_accept = alu_valid && alu_ready;
    ld_accept  = ld_valid && ld_ready;

    // Clear first so a same-edge set of the same index wins.
    pend_nxt = pend;
    if (grant_any && (win_rd != 5'd0)) begin
      pend_nxt[win_rd] = 1'b0;
    end
    if (pend_set && (pend_rd != 5'd0)) begin
      pend_nxt[pend_rd] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  // ---------------------------------------------------------------------
  // Arbiter state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      last_conflict <= SRC_ALU;
    end else begin
      last_conflict <= last_conflict_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Holding slots, write port and scoreboard
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_v      <= 1'b0;
      alu_rd_q   <= 5'd0;
      alu_data_q <= 32'd0;
      ld_v       <= 1'b0;
      ld_rd_q    <= 5'd0;
      ld_data_q  <= 32'd0;
      regWrite   <= 1'b0;
      writePort  <= 5'd0;
      busC       <= 32'd0;
      pend       <= 32'd0;
    end else begin
      if (alu_accept) begin
        alu_v      <= 1'b1;
        alu_rd_q   <= alu_rd;
        alu_data_q <= alu_result;
      end else if (grant_alu) begin
        alu_v <= 1'b0;
      end

      if (ld_accept) begin
        ld_v      <= 1'b1;
        ld_rd_q   <= ld_rd;
        ld_data_q <= ld_fmt;
      end else if (grant_ld) begin
        ld_v <= 1'b0;
      end

      // An x0 entry is consumed without a write so the bank never stalls
      // its read path on x0; the write port keeps its previous value.
      if (grant_any && (win_rd != 5'd0)) begin
        regWrite  <= 1'b1;
        writePort <= win_rd;
        busC      <= win_data;
      end else begin
        regWrite  <= 1'b0;
      end

      pend <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [1:0]  ld_addr_lo;
  logic [2:0]  ld_funct3;
  logic        pend_set;
  logic [4:0]  pend_rd;
  logic [31:0] pend;
  logic        regWrite;
  logic [4:0]  writePort;
  logic [31:0] busC;

  int n_vec;
  int n_err;

  wb_unit dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_result (alu_result),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .ld_addr_lo (ld_addr_lo),
    .ld_funct3  (ld_funct3),
    .pend_set   (pend_set),
    .pend_rd    (pend_rd),
    .pend       (pend),
    .regWrite   (regWrite),
    .writePort  (writePort),
    .busC       (busC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    alu_valid = 1'b0;
    ld_valid = 1'b0;
    pend_set = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready); end
    n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    n_vec++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %b want 0", regWrite); end
    n_vec++; if (pend !== 32'd0) begin n_err++; $display("FAIL reset_pend: got %h want 0", pend); end
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'h0000_0011;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h0000_0044; ld_addr_lo = 2'd0; ld_funct3 = 3'b010;
    pend_set = 1'b1; pend_rd = 5'd9;
    step();
    alu_valid = 1'b0; ld_valid = 1'b0; pend_set = 1'b0;
    n_vec++; if (pend !== 32'h0000_0200) begin n_err++; $display("FAIL pre_reset_pend: got %h want 00000200", pend); end
    rst = 1'b1;
    #1;
    n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL in_reset_alu_ready: got %b want 0", alu_ready); end
    n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL in_reset_ld_ready: got %b want 0", ld_ready); end
    step();
    rst = 1'b0;
    n_vec++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL post_reset_regwrite: got %b want 0", regWrite); end
    n_vec++; if (writePort !== 5'd0) begin n_err++; $display("FAIL post_reset_writeport: got %0d want 0", writePort); end
    n_vec++; if (busC !== 32'd0) begin n_err++; $display("FAIL post_reset_busc: got %h want 0", busC); end
    n_vec++; if (pend !== 32'd0) begin n_err++; $display("FAIL post_reset_pend: got %h want 0", pend); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL dropped_entry_write: cycle %0d got %b want 0", i, regWrite); end
    end
  endtask

  task automatic test_ld_format();
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010};
    logic [1:0]  lo  [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [31:0] exp [6] = '{32'hFFFF_FF85, 32'h0000_0085, 32'h0000_007F,
                             32'hFFFF_80F1, 32'h0000_80F1, 32'h80F1_7F85};
    rst_pulse();
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_data = 32'h80F1_7F85; ld_funct3 = f3[i]; ld_addr_lo = lo[i];
      ld_rd = 5'(10 + i);
      step();
      ld_valid = 1'b0;
      step();
      n_vec++; if (regWrite !== 1'b1) begin n_err++; $display("FAIL fmt_regwrite[%0d]: got %b want 1", i, regWrite); end
      n_vec++; if (writePort !== 5'(10 + i)) begin n_err++; $display("FAIL fmt_writeport[%0d]: got %0d want %0d", i, writePort, 10 + i); end
      n_vec++; if (busC !== exp[i]) begin n_err++; $display("FAIL fmt_busc[%0d]: got %h want %h", i, busC, exp[i]); end
      step();
    end
  endtask

  task automatic test_fairness();
    rst_pulse();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'h0000_0055;
    ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h1234_5678; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    step();
    n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL fair_first_alu_ready: got %b want 0", alu_ready); end
    n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL fair_first_ld_ready: got %b want 1", ld_ready); end
    for (int k = 0; k < 6; k++) begin
      step();
      n_vec++; if (regWrite !== 1'b1) begin n_err++; $display("FAIL fair_regwrite[%0d]: got %b want 1", k, regWrite); end
      n_vec++; if (writePort !== ((k % 2 == 0) ? 5'd6 : 5'd5)) begin n_err++; $display("FAIL fair_writeport[%0d]: got %0d want %0d", k, writePort, (k % 2 == 0) ? 6 : 5); end
      n_vec++; if (busC !== ((k % 2 == 0) ? 32'h1234_5678 : 32'h0000_0055)) begin n_err++; $display("FAIL fair_busc[%0d]: got %h", k, busC); end
      n_vec++; if (alu_ready !== ((k % 2 == 0) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL fair_alu_ready[%0d]: got %b", k, alu_ready); end
      n_vec++; if (ld_ready !== ((k % 2 == 0) ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL fair_ld_ready[%0d]: got %b", k, ld_ready); end
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
  endtask

  task automatic test_x0();
    rst_pulse();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'hDEAD_BEEF;
    pend_set = 1'b1; pend_rd = 5'd0;
    step();
    alu_valid = 1'b0; pend_set = 1'b0;
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready_held: got %b want 1", alu_ready); end
    n_vec++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL x0_regwrite_accept: got %b want 0", regWrite); end
    step();
    n_vec++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL x0_regwrite: got %b want 0", regWrite); end
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready_after: got %b want 1", alu_ready); end
    n_vec++; if (pend !== 32'd0) begin n_err++; $display("FAIL x0_pend: got %h want 0", pend); end
    step();
    n_vec++; if (regWrite !== 1'b0) begin n_err++; $display("FAIL x0_no_late_write: got %b want 0", regWrite); end
  endtask

  task automatic test_scoreboard();
    rst_pulse();
    pend_set = 1'b1; pend_rd = 5'd7;
    step();
    pend_set = 1'b0;
    n_vec++; if (pend !== 32'h0000_0080) begin n_err++; $display("FAIL sb_set: got %h want 00000080", pend); end
    alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 32'h0000_0077;
    step();
    alu_valid = 1'b0;
    pend_set = 1'b1; pend_rd = 5'd7;
    step();
    pend_set = 1'b0;
    n_vec++; if (regWrite !== 1'b1 || writePort !== 5'd7) begin n_err++; $display("FAIL sb_write1: got we=%b port=%0d want we=1 port=7", regWrite, writePort); end
    n_vec++; if (pend !== 32'h0000_0080) begin n_err++; $display("FAIL sb_set_wins: got %h want 00000080", pend); end
    alu_valid = 1'b1; alu_result = 32'h0000_0078;
    step();
    alu_valid = 1'b0;
    n_vec++; if (pend !== 32'h0000_0080) begin n_err++; $display("FAIL sb_still_pending: got %h want 00000080", pend); end
    step();
    n_vec++; if (regWrite !== 1'b1 || busC !== 32'h0000_0078) begin n_err++; $display("FAIL sb_write2: got we=%b busC=%h want we=1 busC=00000078", regWrite, busC); end
    n_vec++; if (pend !== 32'd0) begin n_err++; $display("FAIL sb_clear: got %h want 0", pend); end
  endtask

  task automatic test_back_to_back();
    int ld_writes;
    rst_pulse();
    ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_result = 32'h0000_00A1;
    ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h0000_0B01;
    step();
    alu_valid = 1'b0; ld_valid = 1'b0;
    step();
    n_vec++; if (writePort !== 5'd2) begin n_err++; $display("FAIL bp_first_ld: got %0d want 2", writePort); end
    alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'h0000_00A2;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h0000_0B02;
    step();
    n_vec++; if (writePort !== 5'd1 || busC !== 32'h0000_00A1) begin n_err++; $display("FAIL bp_alu1: got port=%0d busC=%h want 1/000000a1", writePort, busC); end
    alu_valid = 1'b0;
    ld_rd = 5'd5; ld_data = 32'h0000_0B03;
    n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL bp_ld_ready_low: got %b want 0", ld_ready); end
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL bp_alu_ready: got %b want 1", alu_ready); end
    step();
    n_vec++; if (writePort !== 5'd3 || busC !== 32'h0000_00A2) begin n_err++; $display("FAIL bp_alu2: got port=%0d busC=%h want 3/000000a2", writePort, busC); end
    n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL bp_ld_ready_high: got %b want 1", ld_ready); end
    step();
    ld_valid = 1'b0;
    n_vec++; if (regWrite !== 1'b1 || writePort !== 5'd4 || busC !== 32'h0000_0B02) begin n_err++; $display("FAIL bp_old_ld: got we=%b port=%0d busC=%h want 1/4/00000b02", regWrite, writePort, busC); end
    ld_writes = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (regWrite === 1'b1 && writePort === 5'd5 && busC === 32'h0000_0B03) ld_writes++;
      if (i == 0) begin
        n_vec++; if (regWrite !== 1'b1 || writePort !== 5'd5) begin n_err++; $display("FAIL bp_new_ld: got we=%b port=%0d want 1/5", regWrite, writePort); end
      end
    end
    n_vec++; if (ld_writes !== 1) begin n_err++; $display("FAIL bp_write_once: got %0d writes want 1", ld_writes); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_result = 32'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0; ld_addr_lo = 2'd0; ld_funct3 = 3'b010;
    pend_set = 1'b0; pend_rd = 5'd0;
    test_reset();
    test_ld_format();
    test_fairness();
    test_x0();
    test_scoreboard();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
